// File: rtl/pipelined_adder_pkg.sv
// Shared constants for the pipelined add/subtract unit.
package pipelined_adder_pkg;

    // Operation select on SUB_I
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Value loaded into every data register on reset
    localparam logic DATA_RST = 1'b0;

    // Bits per pipeline chunk; WIDTH must be a multiple of STAGES
    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple-carry slice built from full-adder cells.
module adder_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_c,
    output logic [CHUNK-1:0] o_s,
    output logic             o_c,
    output logic             o_cmsb
);

    logic [CHUNK:0] w_cy;

    // Ripple the carry through one full-adder cell per bit
    always_comb begin
        w_cy    = '0;
        o_s     = '0;
        w_cy[0] = i_c;
        for (int i = 0; i < int'(CHUNK); i++) begin
            o_s[i]    = i_a[i] ^ i_b[i] ^ w_cy[i];
            w_cy[i+1] = (i_a[i] & i_b[i]) | (w_cy[i] & (i_a[i] ^ i_b[i]));
        end
        o_c    = w_cy[CHUNK];
        o_cmsb = w_cy[CHUNK-1];
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: one CHUNK-bit ripple slice per stage with the
// carry registered between stages, operand skew and result deskew registers,
// and a global valid/ready stall.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             CLK_I,
    input  logic             RSTN_I,
    input  logic             VALID_I,
    output logic             READY_O,
    input  logic [WIDTH-1:0] A_I,
    input  logic [WIDTH-1:0] B_I,
    input  logic             C_I,
    input  logic             SUB_I,
    output logic             VALID_O,
    input  logic             READY_I,
    output logic [WIDTH-1:0] S_O,
    output logic             C_O,
    output logic             V_O
);

    localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

    logic             w_advance;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;

    // Whole pipeline moves together; a full output that is not taken freezes it
    assign w_advance = !VALID_O || READY_I;
    assign READY_O   = w_advance;

    // Subtract is A + ~B + ~C, so invert once at capture
    assign w_b_eff   = (SUB_I == OP_SUB) ? ~B_I : B_I;
    assign w_cin_eff = (SUB_I == OP_ADD) ? C_I : ~C_I;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [CHUNK-1:0]         w_a;
        logic [CHUNK-1:0]         w_b;
        logic [CHUNK-1:0]         w_s;
        logic                     w_ci;
        logic                     w_co;
        logic                     w_cmsb;
        logic                     w_vld_in;
        logic [CHUNK*(s+1)-1:0]   w_sum_nxt;
        logic [CHUNK*(s+1)-1:0]   r_sum;
        logic                     r_cy;
        logic                     r_vld;

        if (s == 0) begin : g_in
            assign w_a       = A_I[CHUNK-1:0];
            assign w_b       = w_b_eff[CHUNK-1:0];
            assign w_ci      = w_cin_eff;
            assign w_vld_in  = VALID_I;
            assign w_sum_nxt = w_s;
        end else begin : g_in
            assign w_a       = g_stage[s-1].g_skew.r_a_hi[CHUNK-1:0];
            assign w_b       = g_stage[s-1].g_skew.r_b_hi[CHUNK-1:0];
            assign w_ci      = g_stage[s-1].r_cy;
            assign w_vld_in  = g_stage[s-1].r_vld;
            // Deskew: earlier result chunks travel alongside this one
            assign w_sum_nxt = {w_s, g_stage[s-1].r_sum};
        end

        adder_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .i_a    (w_a),
            .i_b    (w_b),
            .i_c    (w_ci),
            .o_s    (w_s),
            .o_c    (w_co),
            .o_cmsb (w_cmsb)
        );

        // Stage register: result chunks so far, chunk carry-out and valid
        always_ff @(posedge CLK_I or negedge RSTN_I) begin
            if (!RSTN_I) begin
                r_sum <= {(CHUNK*(s+1)){DATA_RST}};
                r_cy  <= DATA_RST;
                r_vld <= 1'b0;
            end else if (w_advance) begin
                r_sum <= w_sum_nxt;
                r_cy  <= w_co;
                r_vld <= w_vld_in;
            end
        end

        if (s < STAGES - 1) begin : g_skew
            localparam int unsigned HiW = WIDTH - (s + 1) * CHUNK;
            logic [HiW-1:0] w_a_hi_nxt;
            logic [HiW-1:0] w_b_hi_nxt;
            logic [HiW-1:0] r_a_hi;
            logic [HiW-1:0] r_b_hi;

            if (s == 0) begin : g_src
                assign w_a_hi_nxt = A_I[WIDTH-1:CHUNK];
                assign w_b_hi_nxt = w_b_eff[WIDTH-1:CHUNK];
            end else begin : g_src
                assign w_a_hi_nxt = g_stage[s-1].g_skew.r_a_hi[HiW+CHUNK-1:CHUNK];
                assign w_b_hi_nxt = g_stage[s-1].g_skew.r_b_hi[HiW+CHUNK-1:CHUNK];
            end

            // Skew: not-yet-added operand chunks wait for their stage
            always_ff @(posedge CLK_I or negedge RSTN_I) begin
                if (!RSTN_I) begin
                    r_a_hi <= {HiW{DATA_RST}};
                    r_b_hi <= {HiW{DATA_RST}};
                end else if (w_advance) begin
                    r_a_hi <= w_a_hi_nxt;
                    r_b_hi <= w_b_hi_nxt;
                end
            end
        end

        if (s == STAGES - 1) begin : g_last
            logic r_cmsb;

            // Carry into the MSB, kept for the overflow flag
            always_ff @(posedge CLK_I or negedge RSTN_I) begin
                if (!RSTN_I) begin
                    r_cmsb <= DATA_RST;
                end else if (w_advance) begin
                    r_cmsb <= w_cmsb;
                end
            end
        end else begin : g_mid
            // Only the top chunk's MSB carry matters for overflow
            logic w_cmsb_unused;
            assign w_cmsb_unused = w_cmsb;
        end
    end

    assign VALID_O = g_stage[STAGES-1].r_vld;
    assign S_O     = g_stage[STAGES-1].r_sum;
    assign C_O     = g_stage[STAGES-1].r_cy;
    assign V_O     = g_stage[STAGES-1].g_last.r_cmsb ^ g_stage[STAGES-1].r_cy;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4): directed
// cases with literal expectations plus randomized traffic against a
// queue-based arithmetic model.
module tb_pipelined_adder;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned STAGES = 4;

    logic             clk;
    logic             rst_n;
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             c_i;
    logic             sub_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] s_o;
    logic             c_o;
    logic             v_o;

    int n_cmp = 0;
    int n_err = 0;
    int n_out = 0;
    bit chk_en = 0;

    logic [17:0] exp_q[$];
    bit          hold_q = 0;
    logic [17:0] hold_val;

    pipelined_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .CLK_I   (clk),
        .RSTN_I  (rst_n),
        .VALID_I (valid_i),
        .READY_O (ready_o),
        .A_I     (a_i),
        .B_I     (b_i),
        .C_I     (c_i),
        .SUB_I   (sub_i),
        .VALID_O (valid_o),
        .READY_I (ready_i),
        .S_O     (s_o),
        .C_O     (c_o),
        .V_O     (v_o)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
        end
    endtask

    // Reference result {carry_out, overflow, sum} from plain arithmetic
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic c, input logic sub);
        logic [16:0] full;
        int          sa;
        int          sb;
        int          sr;
        logic        ov;
        if (sub) begin
            full = {1'b0, a} + {1'b0, ~b} + {16'd0, ~c};
            sa = $signed(a);
            sb = $signed(b);
            sr = sa - sb - int'(c);
        end else begin
            full = {1'b0, a} + {1'b0, b} + {16'd0, c};
            sa = $signed(a);
            sb = $signed(b);
            sr = sa + sb + int'(c);
        end
        ov = (sr > 32767) || (sr < -32768);
        return {full[16], ov, full[15:0]};
    endfunction

    // Scoreboard: handshake rule, hold stability, in-order results
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("ready_rule", ready_o, !valid_o || ready_i);
            if (hold_q) begin
                check("hold_valid", valid_o, 1);
                check("hold_data", {c_o, v_o, s_o}, hold_val);
            end
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("spurious_output", {c_o, v_o, s_o}, 32'hDEAD_BEEF);
                end else begin
                    logic [17:0] e;
                    e = exp_q.pop_front();
                    check("out_sum", s_o, e[15:0]);
                    check("out_carry", c_o, e[17]);
                    check("out_ovf", v_o, e[16]);
                end
                n_out++;
            end
            if (valid_i && ready_o) exp_q.push_back(model(a_i, b_i, c_i, sub_i));
            hold_q   = valid_o && !ready_i;
            hold_val = {c_o, v_o, s_o};
        end else begin
            hold_q = 0;
        end
    end

    // One isolated op; checks exact latency and literal results. Call at posedge+1.
    task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic sub,
                         input logic [15:0] es, input logic ec, input logic ev);
        valid_i = 1; a_i = a; b_i = b; c_i = c; sub_i = sub; ready_i = 1;
        @(posedge clk); #1;
        valid_i = 0;
        repeat (2) @(posedge clk);
        #1;
        check({name, "_early"}, valid_o, 0);
        @(posedge clk); #1;
        check({name, "_valid"}, valid_o, 1);
        check({name, "_s"}, s_o, es);
        check({name, "_c"}, c_o, ec);
        check({name, "_v"}, v_o, ev);
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int          idx;
        int          out0;
        int          n_stall;
        bit          acc;
        logic [17:0] m;

        rst_n = 0; valid_i = 0; ready_i = 0;
        a_i = '0; b_i = '0; c_i = 0; sub_i = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_s", s_o, 0);
        check("rst_c", c_o, 0);
        check("rst_v", v_o, 0);
        check("rst_ready", ready_o, 1);
        #2 rst_n = 1;
        @(posedge clk); #1;
        chk_en = 1;

        // Pin the model with hand-computed values
        m = model(16'h7FFF, 16'h0001, 0, 0);
        check("model_ovf_add", m, 18'h18000);
        m = model(16'h0005, 16'h0007, 0, 1);
        check("model_sub_neg", m, 18'h0FFFE);
        m = model(16'h8000, 16'h0001, 0, 1);
        check("model_sub_ovf", m, 18'h37FFF);

        do_op("add_basic", 16'h00FF, 16'h0001, 0, 0, 16'h0100, 0, 0);
        do_op("add_ripple", 16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0);
        do_op("add_ovf", 16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1);
        do_op("sub_neg", 16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0);
        do_op("sub_ovf", 16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1);
        do_op("sub_borrow", 16'h0010, 16'h0001, 1, 1, 16'h000E, 1, 0);

        // Backpressure: 8 ops, READY_I low on cycles 3..5
        idx = 0; out0 = n_out; n_stall = 0;
        for (int cy = 0; cy < 30; cy++) begin
            ready_i = !(cy >= 3 && cy <= 5);
            if (idx < 8) begin
                valid_i = 1; a_i = 16'(idx); b_i = 16'(16'h1000 * idx); c_i = 0; sub_i = 0;
            end else begin
                valid_i = 0;
            end
            @(negedge clk);
            acc = valid_i && ready_o;
            if (!ready_o) n_stall++;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        check("bp_accepted", idx, 8);
        check("bp_delivered", n_out - out0, 8);
        check("bp_stall_cycles", n_stall, 2);
        check("bp_queue_empty", exp_q.size(), 0);

        // Reset with three ops in flight
        ready_i = 1;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1; a_i = 16'(16'h0100 * (i + 1)); b_i = 16'h0011; c_i = 0; sub_i = 0;
            @(posedge clk); #1;
        end
        valid_i = 0;
        #1 rst_n = 0;
        #1;
        check("midrst_valid", valid_o, 0);
        check("midrst_s", s_o, 0);
        check("midrst_ready", ready_o, 1);
        exp_q.delete();
        @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk); #1;
        do_op("post_rst", 16'h1234, 16'h1111, 0, 0, 16'h2345, 0, 0);

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 3) != 0);
            a_i     = pick_operand();
            b_i     = pick_operand();
            c_i     = 1'($urandom);
            sub_i   = 1'($urandom);
            @(posedge clk); #1;
        end
        valid_i = 0; ready_i = 1;
        repeat (STAGES + 4) @(posedge clk);
        #1;
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_valid", valid_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
